// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 initiator.
// Turns a valid/ready command stream into APB transfers with a response.
module apb_cmd_master #(
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0] C_TO  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] C_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t                r_state;
   state_t                w_state;
   logic                  r_req_ready, w_req_ready;
   logic                  r_rsp_valid, w_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
   logic                  r_rsp_err, w_rsp_err;
   logic                  r_rsp_to, w_rsp_to;
   logic                  r_busy, w_busy;
   logic                  r_psel, w_psel;
   logic                  r_penable, w_penable;
   logic                  r_pwrite, w_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata;
   logic [CW-1:0]         r_cnt, w_cnt;
   logic [CW-1:0]         w_cnt_inc;

   always_comb begin
      w_state     = r_state;
      w_req_ready = r_req_ready;
      w_rsp_valid = r_rsp_valid;
      w_rsp_rdata = r_rsp_rdata;
      w_rsp_err   = r_rsp_err;
      w_rsp_to    = r_rsp_to;
      w_busy      = r_busy;
      w_psel      = r_psel;
      w_penable   = r_penable;
      w_pwrite    = r_pwrite;
      w_paddr     = r_paddr;
      w_pwdata    = r_pwdata;
      w_cnt       = r_cnt;
      // saturating wait counter, never wraps
      w_cnt_inc   = (r_cnt == C_MAX) ? r_cnt : r_cnt + CW'(1);
      unique case (r_state)
         S_IDLE: begin
            if (req_valid && r_req_ready) begin
               w_state     = S_SETUP;
               w_req_ready = 1'b0;
               w_busy      = 1'b1;
               w_psel      = 1'b1;
               w_pwrite    = req_write;
               w_paddr     = req_addr;
               w_pwdata    = req_wdata;
               w_cnt       = '0;
            end
         end
         S_SETUP: begin
            w_state   = S_ACCESS;
            w_penable = 1'b1;
         end
         S_ACCESS: begin
            if (PREADY) begin
               w_state     = S_RESP;
               w_psel      = 1'b0;
               w_penable   = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_rdata = r_pwrite ? '0 : PRDATA;
               w_rsp_err   = PSLVERR;
               w_rsp_to    = 1'b0;
            end else begin
               w_cnt = w_cnt_inc;
               if (TO_EN && (w_cnt_inc == C_TO)) begin
                  w_state     = S_RESP;
                  w_psel      = 1'b0;
                  w_penable   = 1'b0;
                  w_rsp_valid = 1'b1;
                  w_rsp_rdata = '0;
                  w_rsp_err   = 1'b1;
                  w_rsp_to    = 1'b1;
               end
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state     = S_IDLE;
               w_rsp_valid = 1'b0;
               w_req_ready = 1'b1;
               w_busy      = 1'b0;
               w_cnt       = '0;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_to    <= 1'b0;
         r_busy      <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state;
         r_req_ready <= w_req_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_rdata <= w_rsp_rdata;
         r_rsp_err   <= w_rsp_err;
         r_rsp_to    <= w_rsp_to;
         r_busy      <= w_busy;
         r_psel      <= w_psel;
         r_penable   <= w_penable;
         r_pwrite    <= w_pwrite;
         r_paddr     <= w_paddr;
         r_pwdata    <= w_pwdata;
         r_cnt       <= w_cnt;
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_to;
   assign busy        = r_busy;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized bench for apb_cmd_master with a
// transaction-level model of expected APB timing and responses.
module tb_apb_cmd_master;

   localparam int AW   = 5;
   localparam int DW   = 8;
   localparam int TO   = 4;
   localparam int NMAX = 64;

   logic          PCLK = 1'b0;
   logic          PRESETN = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          busy;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA = '0;
   logic          PREADY = 1'b0;
   logic          PSLVERR = 1'b0;

   apb_cmd_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .PCLK        (PCLK),
      .PRESETN     (PRESETN),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // command list and per-command slave behaviour
   logic          c_wr   [NMAX];
   logic [AW-1:0] c_addr [NMAX];
   logic [DW-1:0] c_wd   [NMAX];
   int            p_wait [NMAX];
   logic          p_err  [NMAX];
   logic [DW-1:0] p_rd   [NMAX];
   int            rv_len [NMAX];

   int n_cmd = 0;
   int n_acc = 0;
   int rsp_idx = 0;
   int n_chk = 0;
   int n_fail = 0;
   int rr_block = 0;
   bit rr_rand = 1'b0;

   int            last_len = 0;
   logic [DW-1:0] last_rd = '0;
   logic          last_err = 1'b0;
   logic          last_to = 1'b0;

   bit rst_pend = 1'b1;
   bit fire_prev = 1'b0;
   bit p_psel = 1'b0;
   bit p_rv = 1'b0;
   int run = 0;
   int rvr = 0;
   int sl_k = 0;
   int cur = 0;
   int base = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic bit m_to(input int i);
      return p_wait[i] >= TO;
   endfunction

   function automatic int m_len(input int i);
      return 1 + (m_to(i) ? TO : p_wait[i] + 1);
   endfunction

   function automatic logic m_err(input int i);
      return m_to(i) ? 1'b1 : p_err[i];
   endfunction

   function automatic logic [DW-1:0] m_rd(input int i);
      return (m_to(i) || c_wr[i]) ? '0 : p_rd[i];
   endfunction

   task automatic add(input logic wr, input int addr, input int wd,
                      input int w, input logic err, input int rd);
      c_wr[n_cmd]   = wr;
      c_addr[n_cmd] = AW'(addr);
      c_wd[n_cmd]   = DW'(wd);
      p_wait[n_cmd] = w;
      p_err[n_cmd]  = err;
      p_rd[n_cmd]   = DW'(rd);
      n_cmd++;
   endtask

   task automatic wait_done(input string name);
      int c;
      c = 0;
      while (rsp_idx < n_cmd && c < 3000) begin
         @(posedge PCLK);
         c++;
      end
      chk({name, "_done"}, rsp_idx, n_cmd);
   endtask

   // command source
   initial forever begin
      @(negedge PCLK);
      if (n_acc < n_cmd) begin
         req_valid = 1'b1;
         req_write = c_wr[n_acc];
         req_addr  = c_addr[n_acc];
         req_wdata = c_wd[n_acc];
      end else begin
         req_valid = 1'b0;
         req_write = 1'($urandom);
         req_addr  = AW'($urandom);
         req_wdata = DW'($urandom);
      end
   end

   // APB slave: junk on PREADY/PSLVERR/PRDATA outside the ready cycle
   initial forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
         sl_k++;
         PREADY = (sl_k == p_wait[n_acc-1] + 1);
      end else begin
         sl_k = 0;
         PREADY = 1'($urandom);
      end
      if (PSEL && PENABLE && PREADY) begin
         PRDATA  = p_rd[n_acc-1];
         PSLVERR = p_err[n_acc-1];
      end else begin
         PRDATA  = DW'($urandom);
         PSLVERR = 1'($urandom);
      end
   end

   // response sink
   initial forever begin
      @(negedge PCLK);
      if (rsp_valid && rr_block > 0) begin
         rsp_ready = 1'b0;
         rr_block--;
      end else if (rr_rand) begin
         rsp_ready = 1'($urandom);
      end else begin
         rsp_ready = 1'b1;
      end
   end

   // cycle checker against the transaction model
   initial forever begin
      @(negedge PCLK);
      #2;
      if (rst_pend) begin
         chk("rst_psel", 32'(PSEL), 0);
         chk("rst_pen", 32'(PENABLE), 0);
         chk("rst_pwrite", 32'(PWRITE), 0);
         chk("rst_paddr", 32'(PADDR), 0);
         chk("rst_pwdata", 32'(PWDATA), 0);
         chk("rst_rv", 32'(rsp_valid), 0);
         chk("rst_err", 32'(rsp_err), 0);
         chk("rst_to", 32'(rsp_timeout), 0);
         chk("rst_rd", 32'(rsp_rdata), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_ready", 32'(req_ready), 1);
         rsp_idx = n_acc;
         run = 0;
         rvr = 0;
         p_psel = 1'b0;
         p_rv = 1'b0;
      end else begin
         chk("ready_vs_busy", 32'(req_ready), 32'(!busy));
         if (fire_prev) begin
            chk("setup_psel", 32'(PSEL), 1);
            chk("setup_pen", 32'(PENABLE), 0);
            chk("setup_ready", 32'(req_ready), 0);
         end
         if (PSEL) begin
            cur = n_acc - 1;
            chk("paddr", 32'(PADDR), 32'(c_addr[cur]));
            chk("pwrite", 32'(PWRITE), 32'(c_wr[cur]));
            chk("pwdata", 32'(PWDATA), 32'(c_wd[cur]));
            chk("pen_phase", 32'(PENABLE), 32'(run > 0));
            chk("rv_in_xfer", 32'(rsp_valid), 0);
            run++;
         end else begin
            chk("pen_idle", 32'(PENABLE), 0);
            if (p_psel) begin
               chk("psel_len", run, m_len(n_acc - 1));
               chk("rv_after_xfer", 32'(rsp_valid), 1);
               last_len = run;
            end
            run = 0;
         end
         if (rsp_valid) begin
            chk("rsp_order", rsp_idx, n_acc - 1);
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rd(rsp_idx)));
            chk("rsp_err", 32'(rsp_err), 32'(m_err(rsp_idx)));
            chk("rsp_to", 32'(rsp_timeout), 32'(m_to(rsp_idx)));
            if (!p_rv) chk("rv_rise", 32'(p_psel), 1);
            rvr++;
            if (rsp_ready) begin
               rv_len[rsp_idx] = rvr;
               last_rd  = rsp_rdata;
               last_err = rsp_err;
               last_to  = rsp_timeout;
               rsp_idx++;
               rvr = 0;
            end
         end
         if (req_ready) begin
            chk("idle_psel", 32'(PSEL), 0);
            chk("idle_rv", 32'(rsp_valid), 0);
         end
         p_psel = PSEL;
         p_rv = rsp_valid;
      end
      fire_prev = req_valid && req_ready && PRESETN;
      if (fire_prev) begin
         chk("accept_order", n_acc, rsp_idx);
         n_acc++;
      end
      rst_pend = !PRESETN;
   end

   initial begin
      int c;
      repeat (3) @(negedge PCLK);
      PRESETN = 1'b1;
      @(posedge PCLK);

      add(1'b1, 'h00, 'hA5, 0, 1'b0, 'h00);
      wait_done("t1");
      chk("t1_len", last_len, 2);
      chk("t1_err", 32'(last_err), 0);
      chk("t1_rd", 32'(last_rd), 0);

      add(1'b0, 'h04, 'h77, 3, 1'b0, 'h3C);
      wait_done("t2");
      chk("t2_len", last_len, 5);
      chk("t2_rd", 32'(last_rd), 'h3C);
      chk("t2_err", 32'(last_err), 0);

      add(1'b1, 'h0A, 'h55, 0, 1'b1, 'h99);
      wait_done("t3");
      chk("t3_err", 32'(last_err), 1);
      chk("t3_to", 32'(last_to), 0);
      chk("t3_rd", 32'(last_rd), 0);

      add(1'b0, 'h10, 'h00, 9, 1'b0, 'hEE);
      wait_done("t4");
      chk("t4_len", last_len, 5);
      chk("t4_err", 32'(last_err), 1);
      chk("t4_to", 32'(last_to), 1);
      chk("t4_rd", 32'(last_rd), 0);

      rr_block = 5;
      base = n_cmd;
      add(1'b1, 'h01, 'h11, 0, 1'b0, 'h00);
      add(1'b0, 'h02, 'h22, 1, 1'b0, 'h5A);
      add(1'b1, 'h03, 'h33, 2, 1'b1, 'h00);
      wait_done("t5");
      chk("t5_rv_len", rv_len[base], 6);
      chk("t5_last_err", 32'(last_err), 1);

      add(1'b0, 'h05, 'h00, 3, 1'b0, 'h11);
      c = 0;
      do begin
         @(negedge PCLK);
         c++;
      end while (!(PSEL && PENABLE) && c < 50);
      chk("t6_reach_access", c < 50, 1);
      PRESETN = 1'b0;
      @(negedge PCLK);
      PRESETN = 1'b1;
      @(posedge PCLK);
      wait_done("t6_abort");
      add(1'b0, 'h06, 'h00, 1, 1'b0, 'hC3);
      wait_done("t6");
      chk("t6_rd", 32'(last_rd), 'hC3);
      chk("t6_len", last_len, 3);

      rr_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         add(1'($urandom), int'($urandom_range(31, 0)),
             int'($urandom_range(255, 0)), int'($urandom_range(5, 0)),
             1'($urandom), int'($urandom_range(255, 0)));
      end
      wait_done("rand");

      repeat (2) @(posedge PCLK);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-outstanding APB3 initiator that turns a valid/ready command stream into APB read/write transfers and returns a response.
- Sits between a local command source (sequencer, soft-processor bridge or test stimulus engine) and CoreUARTapb-style APB slaves, such as the UART TX/RX register ports.
- Replaces the behavioural APB master BFM with synthesizable logic.

Parameters:
- ADDR_WIDTH, 5, width of PADDR and req_addr.
- DATA_WIDTH, 8, width of PWDATA/PRDATA and request/response data.
- TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- PCLK  input  1  single clock, rising edge.
- PRESETN  input  1  reset; synchronous, active-low.
- req_valid  input  1  command present.
- req_ready  output  1  block can accept a command.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  target register address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer ready.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_err  output  1  PSLVERR seen or timeout.
- rsp_timeout  output  1  transfer ended by timeout.
- busy  output  1  transfer or response pending.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready; tie high for slaves without wait states.
- PSLVERR  input  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset state (PRESETN low at a PCLK edge):
  - state = IDLE.
  - PSEL = PENABLE = PWRITE = 0; PADDR = PWDATA = 0.
  - rsp_valid = rsp_err = rsp_timeout = 0; rsp_rdata = 0; busy = 0; timeout counter = 0.
- Reset mid-transfer aborts immediately: PSEL/PENABLE drop at that edge and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch req_write/addr/wdata into PWRITE/PADDR/PWDATA; go to SETUP.
- SETUP (one cycle):
  - PSEL = 1, PENABLE = 0; next state ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR/PWRITE/PWDATA are held stable throughout SETUP and ACCESS.
  - Each cycle with PREADY = 0 increments the counter.
  - If PREADY = 1 is sampled:
    - capture PRDATA into rsp_rdata on reads only (writes return 0);
    - rsp_err = PSLVERR; rsp_timeout = 0;
    - drop PSEL/PENABLE; go to RESP.
  - If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0:
    - drop PSEL/PENABLE; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; go to RESP.
- RESP:
  - rsp_valid = 1; hold rsp_* stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid = 0, counter cleared, go to IDLE.
- busy = 1 in every state except IDLE.
- req_ready = 0 outside IDLE; a req_valid asserted then waits, and no request is lost or duplicated.
- Latency with zero wait states: accept edge N; SETUP visible N+1; ACCESS N+2; rsp_valid N+3.
- Back-to-back throughput: one transfer per 4 cycles if rsp_ready is held high.
- The next request is accepted the cycle after the response handshake. IDLE is always at least one cycle, so PSEL is guaranteed to drop between transfers.
- PSLVERR and PRDATA are ignored whenever PENABLE & PREADY are not both 1.
- Counter width is ceil(log2(TIMEOUT_CYCLES+1)) and saturates; it never wraps.
- Simultaneous PREADY and timeout in the same cycle: PREADY wins, rsp_timeout = 0.

Test Plan:
1. Write, zero wait: req write addr 0x00 data 0xA5, PREADY = 1 → PSEL at N+1 with PENABLE = 0, PENABLE at N+2, PWDATA = 0xA5 and PADDR = 0x00 stable both cycles; rsp_valid at N+3 with rsp_err = 0.
2. Read with waits: read addr 0x04, PREADY low 3 ACCESS cycles, PRDATA = 0x3C on the ready cycle → rsp_rdata = 0x3C at ready edge + 1; PSEL high exactly 5 cycles.
3. Slave error: write with PSLVERR = 1 and PREADY = 1 → rsp_err = 1, rsp_timeout = 0; PSLVERR pulses while PENABLE = 0 have no effect.
4. Timeout: TIMEOUT_CYCLES = 4, PREADY held 0 → PSEL drops after 4 ACCESS wait cycles; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
5. Backpressure/back-to-back: req_valid held with 3 queued commands, rsp_ready low 5 cycles on the first → req_ready stays 0, no second PSEL until the handshake; all 3 complete in order, PSEL low ≥ 1 cycle between them.
6. Reset mid-ACCESS: PRESETN low for 1 edge during a wait state → PSEL/PENABLE = 0 and rsp_valid = 0 after that edge; a fresh read completes normally afterwards.
